// File: rtl/game_pkg.sv
// Shared constants and types for the ball game video path.
// Combinational helpers only, so no latency.
// No flow control lives here.
package game_pkg;

  // Ball box edge in pixels.
  localparam int BALL_SIZE_DEFAULT = 20;

  // Visible raster size.
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EVAL
  } hit_state_t;

  // Unsigned distance between two columns. It cannot overflow 10 bits.
  function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/hit_speed_detector_frame_edge_detect.sv
// Detects the leading edge of a sync pulse using a registered copy of the sync line.
// The pulse is combinational from the live sync input and lasts one cycle.
// There is no backpressure; the module sees every sync transition.
module frame_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk_25MHZ,
  input  logic reset,
  input  logic sync,
  output logic frame_edge
);

  logic sync_q;

  // Keep the previous sync level. Reset sets it to the inactive level so that no false edge appears.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) sync_q <= ACTIVE_LOW;
    else       sync_q <= sync;
  end

  assign frame_edge = ACTIVE_LOW ? (sync_q & ~sync) : (~sync_q & sync);

endmodule

// File: rtl/hit_speed_detector.sv
// Counts object-mask pixels inside the grown ball box and pulses collision_detected once per qualifying frame.
// Pixel-to-accumulator latency is 1 cycle. The pulse appears 1 cycle after the frame edge is sampled.
// This is a streaming design with no backpressure. Every DE-qualified pixel is consumed.
module hit_speed_detector
  import game_pkg::*;
#(
  parameter int BALL_SIZE       = BALL_SIZE_DEFAULT,
  parameter int MARGIN          = 2,
  parameter int HIT_THRESH      = 16,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int CNT_W           = 16
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       DE,
  input  logic       v_sync,
  input  logic       mask,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       collision_detected,
  output logic [9:0] estimated_speed,
  output logic       frame_valid
);

  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

  // The bounds use 12 signed bits. A ball near column 0 gives a negative lower bound, which clamps the box to column 0.
  // A ball near column 1023 must not wrap its upper bound.
  localparam logic signed [11:0] LO_OFF = 12'(MARGIN);
  localparam logic signed [11:0] HI_OFF = 12'(BALL_SIZE - 1 + MARGIN);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  logic             frame_edge;
  logic [9:0]       x_q, y_q;
  logic             de_q, mask_q;
  hit_state_t       state;
  logic [9:0]       bx, by;
  logic [CNT_W-1:0] hit_cnt;
  logic [9:0]       cur_min, prev_min;
  logic             cur_valid, prev_valid;
  logic [CD_W-1:0]  cooldown;

  logic signed [11:0] x_lo, x_hi, y_lo, y_hi, xs, ys;
  logic               in_box, pix_hit, hit_now;

  frame_edge_detect #(.ACTIVE_LOW(1'b1)) u_edge (
    .clk_25MHZ (clk_25MHZ),
    .reset     (reset),
    .sync      (v_sync),
    .frame_edge(frame_edge)
  );

  // Register the pixel stream once. The overlap test works on this stage.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      de_q   <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      x_q    <= x_pixel;
      y_q    <= y_pixel;
      de_q   <= DE;
      mask_q <= mask;
    end
  end

  assign xs      = $signed({2'b00, x_q});
  assign ys      = $signed({2'b00, y_q});
  assign x_lo    = $signed({2'b00, bx}) - LO_OFF;
  assign x_hi    = $signed({2'b00, bx}) + HI_OFF;
  assign y_lo    = $signed({2'b00, by}) - LO_OFF;
  assign y_hi    = $signed({2'b00, by}) + HI_OFF;
  assign in_box  = (xs >= x_lo) && (xs <= x_hi) && (ys >= y_lo) && (ys <= y_hi);
  assign pix_hit = de_q & mask_q;
  assign hit_now = (hit_cnt >= CNT_W'(HIT_THRESH)) && (cooldown == '0);

  // Frame FSM: accumulate over the frame, then evaluate for one cycle at each frame edge.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      collision_detected <= 1'b0;
      estimated_speed    <= '0;
      frame_valid        <= 1'b0;
      hit_cnt            <= '0;
      cur_min            <= '1;
      cur_valid          <= 1'b0;
      prev_min           <= '1;
      prev_valid         <= 1'b0;
      cooldown           <= '0;
      bx                 <= '0;
      by                 <= '0;
    end else begin
      collision_detected <= 1'b0;
      case (state)
        IDLE: begin
          // Pixels seen before the first edge belong to a partial frame and are dropped.
          if (frame_edge) begin
            state     <= ACCUM;
            bx        <= ball_x;
            by        <= ball_y;
            hit_cnt   <= '0;
            cur_min   <= '1;
            cur_valid <= 1'b0;
          end
        end
        ACCUM: begin
          if (pix_hit) begin
            if (x_q < cur_min) cur_min <= x_q;
            cur_valid <= 1'b1;
            if (in_box && (hit_cnt != CNT_MAX)) hit_cnt <= hit_cnt + CNT_W'(1);
          end
          if (frame_edge) state <= EVAL;
        end
        EVAL: begin
          if (hit_now) begin
            collision_detected <= 1'b1;
            cooldown           <= CD_W'(COOLDOWN_FRAMES);
          end else if (cooldown != '0) begin
            cooldown <= cooldown - CD_W'(1);
          end
          estimated_speed <= (cur_valid && prev_valid) ? abs_diff10(cur_min, prev_min) : '0;
          prev_min        <= cur_min;
          prev_valid      <= cur_valid;
          frame_valid     <= 1'b1;
          // A second edge arriving here is ignored. The next frame starts at once.
          state     <= ACCUM;
          bx        <= ball_x;
          by        <= ball_y;
          hit_cnt   <= '0;
          cur_min   <= '1;
          cur_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
